// File: rtl/rs_pkg.sv
// Shared types for the integer ALU reservation station:
// opcode encodings, default widths and the entry layout.
package rs_pkg;

    localparam int TAG_W = 4;
    localparam int OP_W  = 5;

    typedef enum logic [OP_W-1:0] {
        OP_ADD   = 5'd0,
        OP_SUB   = 5'd1,
        OP_AND   = 5'd2,
        OP_OR    = 5'd3,
        OP_XOR   = 5'd4,
        OP_SLL   = 5'd5,
        OP_SRL   = 5'd6,
        OP_SRA   = 5'd7,
        OP_SLT   = 5'd8,
        OP_SLTU  = 5'd9,
        OP_EQ    = 5'd10,
        OP_NE    = 5'd11,
        OP_GE    = 5'd12,
        OP_GEU   = 5'd13,
        OP_SLTI  = 5'd14,
        OP_SLTIU = 5'd15,
        OP_MUL   = 5'd16
    } alu_op_e;

    typedef struct packed {
        logic             busy;
        logic [OP_W-1:0]  op;
        logic [TAG_W-1:0] tag;
        logic [31:0]      vj;
        logic [31:0]      vk;
        logic [TAG_W-1:0] qj;
        logic [TAG_W-1:0] qk;
        logic             pj;
        logic             pk;
    } rs_entry_t;

endpackage

// File: rtl/rs_pick.sv
// Lowest-index priority encoder: reports whether any request
// is set and the index of the lowest one.
module rs_pick #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    output logic          found,
    output logic [IW-1:0] idx
);

    always_comb begin
        found = 1'b0;
        idx   = '0;
        // Scan downwards so the lowest set bit wins.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                idx   = IW'(i);
            end
        end
    end

endmodule

// File: rtl/alu_rs.sv
// Integer ALU reservation station: tag-based operand wakeup from
// two result buses and one in-order-by-slot issue per cycle.
module alu_rs #(
    parameter int DEPTH = 4,
    parameter int TAG_W = rs_pkg::TAG_W,
    parameter int OP_W  = rs_pkg::OP_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             disp_valid,
    input  logic [OP_W-1:0]  disp_op,
    input  logic [TAG_W-1:0] disp_tag,
    input  logic [31:0]      disp_vj,
    input  logic [31:0]      disp_vk,
    input  logic [TAG_W-1:0] disp_qj,
    input  logic [TAG_W-1:0] disp_qk,
    input  logic             disp_pj,
    input  logic             disp_pk,
    output logic             rs_full,
    input  logic             cdb_alu_done,
    input  logic [TAG_W-1:0] cdb_alu_tag,
    input  logic [31:0]      cdb_alu_data,
    input  logic             cdb_lsb_done,
    input  logic [TAG_W-1:0] cdb_lsb_tag,
    input  logic [31:0]      cdb_lsb_data,
    output logic             alu_ready,
    output logic [31:0]      a,
    output logic [31:0]      b,
    output logic [OP_W-1:0]  alu_op,
    output logic [TAG_W-1:0] tag
);

    import rs_pkg::*;

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    rs_entry_t ent_q [DEPTH];
    rs_entry_t ent_d [DEPTH];
    rs_entry_t new_e;

    logic [DEPTH-1:0] free_v;
    logic [DEPTH-1:0] ready_v;
    logic             free_found;
    logic             issue_found;
    logic [IW-1:0]    free_idx;
    logic [IW-1:0]    issue_idx;
    logic             accept;
    logic [CW-1:0]    count;
    logic [CW-1:0]    next_count;

    function automatic logic hit(
        input logic             done,
        input logic [TAG_W-1:0] bus_tag,
        input logic [TAG_W-1:0] q
    );
        return done && (bus_tag == q);
    endfunction

    always_comb begin
        count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            free_v[i]  = !ent_q[i].busy;
            ready_v[i] = ent_q[i].busy && !ent_q[i].pj && !ent_q[i].pk;
            count      = count + CW'(ent_q[i].busy);
        end
    end

    rs_pick #(.N(DEPTH)) u_free (
        .req   (free_v),
        .found (free_found),
        .idx   (free_idx)
    );

    rs_pick #(.N(DEPTH)) u_issue (
        .req   (ready_v),
        .found (issue_found),
        .idx   (issue_idx)
    );

    assign accept     = disp_valid && !rs_full && !flush && free_found;
    assign next_count = count + CW'(accept) - CW'(issue_found);

    always_comb begin
        new_e      = '0;
        new_e.busy = 1'b1;
        new_e.op   = disp_op;
        new_e.tag  = disp_tag;
        new_e.vj   = disp_vj;
        new_e.vk   = disp_vk;
        new_e.qj   = disp_qj;
        new_e.qk   = disp_qk;
        new_e.pj   = disp_pj;
        new_e.pk   = disp_pk;
        // Catch a producer that broadcasts in the dispatch cycle.
        if (disp_pj) begin
            if (hit(cdb_alu_done, cdb_alu_tag, disp_qj)) begin
                new_e.vj = cdb_alu_data;
                new_e.pj = 1'b0;
            end else if (hit(cdb_lsb_done, cdb_lsb_tag, disp_qj)) begin
                new_e.vj = cdb_lsb_data;
                new_e.pj = 1'b0;
            end
        end
        if (disp_pk) begin
            if (hit(cdb_alu_done, cdb_alu_tag, disp_qk)) begin
                new_e.vk = cdb_alu_data;
                new_e.pk = 1'b0;
            end else if (hit(cdb_lsb_done, cdb_lsb_tag, disp_qk)) begin
                new_e.vk = cdb_lsb_data;
                new_e.pk = 1'b0;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = ent_q[i];
            if (ent_q[i].busy && ent_q[i].pj) begin
                if (hit(cdb_alu_done, cdb_alu_tag, ent_q[i].qj)) begin
                    ent_d[i].vj = cdb_alu_data;
                    ent_d[i].pj = 1'b0;
                end else if (hit(cdb_lsb_done, cdb_lsb_tag, ent_q[i].qj)) begin
                    ent_d[i].vj = cdb_lsb_data;
                    ent_d[i].pj = 1'b0;
                end
            end
            if (ent_q[i].busy && ent_q[i].pk) begin
                if (hit(cdb_alu_done, cdb_alu_tag, ent_q[i].qk)) begin
                    ent_d[i].vk = cdb_alu_data;
                    ent_d[i].pk = 1'b0;
                end else if (hit(cdb_lsb_done, cdb_lsb_tag, ent_q[i].qk)) begin
                    ent_d[i].vk = cdb_lsb_data;
                    ent_d[i].pk = 1'b0;
                end
            end
        end
        // Issue slot is busy and the free slot is not, so they never collide.
        if (issue_found) ent_d[issue_idx].busy = 1'b0;
        if (accept)      ent_d[free_idx] = new_e;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
            rs_full   <= 1'b0;
            alu_ready <= 1'b0;
            a         <= '0;
            b         <= '0;
            alu_op    <= '0;
            tag       <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i].busy <= 1'b0;
            rs_full   <= 1'b0;
            alu_ready <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
            rs_full   <= (next_count == CW'(DEPTH));
            alu_ready <= issue_found;
            if (issue_found) begin
                a      <= ent_q[issue_idx].vj;
                b      <= ent_q[issue_idx].vk;
                alu_op <= ent_q[issue_idx].op;
                tag    <= ent_q[issue_idx].tag;
            end
        end
    end

endmodule

// File: tb/tb_alu_rs.sv
// Directed self-checking bench for the ALU reservation station.
module tb_alu_rs;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        disp_valid;
    logic [4:0]  disp_op;
    logic [3:0]  disp_tag;
    logic [31:0] disp_vj;
    logic [31:0] disp_vk;
    logic [3:0]  disp_qj;
    logic [3:0]  disp_qk;
    logic        disp_pj;
    logic        disp_pk;
    logic        rs_full;
    logic        cdb_alu_done;
    logic [3:0]  cdb_alu_tag;
    logic [31:0] cdb_alu_data;
    logic        cdb_lsb_done;
    logic [3:0]  cdb_lsb_tag;
    logic [31:0] cdb_lsb_data;
    logic        alu_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  alu_op;
    logic [3:0]  tag;

    int checks = 0;
    int errors = 0;

    alu_rs #(.DEPTH(4), .TAG_W(4), .OP_W(5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .disp_valid   (disp_valid),
        .disp_op      (disp_op),
        .disp_tag     (disp_tag),
        .disp_vj      (disp_vj),
        .disp_vk      (disp_vk),
        .disp_qj      (disp_qj),
        .disp_qk      (disp_qk),
        .disp_pj      (disp_pj),
        .disp_pk      (disp_pk),
        .rs_full      (rs_full),
        .cdb_alu_done (cdb_alu_done),
        .cdb_alu_tag  (cdb_alu_tag),
        .cdb_alu_data (cdb_alu_data),
        .cdb_lsb_done (cdb_lsb_done),
        .cdb_lsb_tag  (cdb_lsb_tag),
        .cdb_lsb_data (cdb_lsb_data),
        .alu_ready    (alu_ready),
        .a            (a),
        .b            (b),
        .alu_op       (alu_op),
        .tag          (tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_disp(
        input logic        v,
        input logic [4:0]  op,
        input logic [3:0]  tg,
        input logic [31:0] vj,
        input logic [31:0] vk,
        input logic [3:0]  qj,
        input logic [3:0]  qk,
        input logic        pj,
        input logic        pk
    );
        disp_valid = v;
        disp_op    = op;
        disp_tag   = tg;
        disp_vj    = vj;
        disp_vk    = vk;
        disp_qj    = qj;
        disp_qk    = qk;
        disp_pj    = pj;
        disp_pk    = pk;
    endtask

    task automatic cdb_idle();
        cdb_alu_done = 1'b0;
        cdb_alu_tag  = '0;
        cdb_alu_data = '0;
        cdb_lsb_done = 1'b0;
        cdb_lsb_tag  = '0;
        cdb_lsb_data = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        flush = 1'b0;
        set_disp(1'b0, 5'd0, 4'd0, 32'd0, 32'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        cdb_idle();
        tick();
        tick();
        checks++;
        if (alu_ready !== 1'b0 || rs_full !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got ready=%b full=%b want 0 0", alu_ready, rs_full);
        end
        checks++;
        if (a !== 32'd0 || b !== 32'd0 || alu_op !== 5'd0 || tag !== 4'd0) begin
            errors++;
            $display("FAIL reset_data got a=%h b=%h op=%0d tag=%0d want zeros", a, b, alu_op, tag);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_dispatch();
        set_disp(1'b1, 5'd0, 4'd2, 32'd5, 32'd7, 4'd0, 4'd0, 1'b0, 1'b0);
        tick();
        set_disp(1'b0, 5'd0, 4'd0, 32'd0, 32'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        tick();
        checks++;
        if (alu_ready !== 1'b1 || a !== 32'd5 || b !== 32'd7 || alu_op !== 5'd0 || tag !== 4'd2) begin
            errors++;
            $display("FAIL dispatch_add got rdy=%b a=%0d b=%0d op=%0d tag=%0d want 1 5 7 0 2",
                     alu_ready, a, b, alu_op, tag);
        end
        tick();
        checks++;
        if (alu_ready !== 1'b0 || a !== 32'd5 || tag !== 4'd2) begin
            errors++;
            $display("FAIL idle_hold got rdy=%b a=%0d tag=%0d want 0 5 2", alu_ready, a, tag);
        end
    endtask

    task automatic test_wakeup();
        set_disp(1'b1, 5'd1, 4'd4, 32'd0, 32'd1, 4'd3, 4'd0, 1'b1, 1'b0);
        tick();
        set_disp(1'b0, 5'd0, 4'd0, 32'd0, 32'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        cdb_lsb_done = 1'b1;
        cdb_lsb_tag  = 4'd3;
        cdb_lsb_data = 32'd10;
        tick();
        cdb_idle();
        checks++;
        if (alu_ready !== 1'b0) begin
            errors++;
            $display("FAIL wakeup_early got rdy=%b want 0", alu_ready);
        end
        tick();
        checks++;
        if (alu_ready !== 1'b1 || a !== 32'd10 || b !== 32'd1 || alu_op !== 5'd1 || tag !== 4'd4) begin
            errors++;
            $display("FAIL wakeup_issue got rdy=%b a=%0d b=%0d op=%0d tag=%0d want 1 10 1 1 4",
                     alu_ready, a, b, alu_op, tag);
        end
        tick();
    endtask

    task automatic test_forward();
        set_disp(1'b1, 5'd2, 4'd7, 32'd9, 32'd0, 4'd0, 4'd6, 1'b0, 1'b1);
        cdb_alu_done = 1'b1;
        cdb_alu_tag  = 4'd6;
        cdb_alu_data = 32'h55;
        tick();
        cdb_idle();
        set_disp(1'b0, 5'd0, 4'd0, 32'd0, 32'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        tick();
        checks++;
        if (alu_ready !== 1'b1 || a !== 32'd9 || b !== 32'h55 || alu_op !== 5'd2 || tag !== 4'd7) begin
            errors++;
            $display("FAIL forward_issue got rdy=%b a=%h b=%h op=%0d tag=%0d want 1 9 55 2 7",
                     alu_ready, a, b, alu_op, tag);
        end
        tick();
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++) begin
            set_disp(1'b1, 5'd0, 4'(12 + i), 32'd0, 32'(i), 4'(8 + i), 4'd0, 1'b1, 1'b0);
            tick();
        end
        checks++;
        if (rs_full !== 1'b1) begin
            errors++;
            $display("FAIL full_set got %b want 1", rs_full);
        end
        set_disp(1'b1, 5'd0, 4'd1, 32'h77, 32'h77, 4'd0, 4'd0, 1'b0, 1'b0);
        tick();
        set_disp(1'b0, 5'd0, 4'd0, 32'd0, 32'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        checks++;
        if (rs_full !== 1'b1) begin
            errors++;
            $display("FAIL full_hold got %b want 1", rs_full);
        end
        tick();
        checks++;
        if (alu_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_reject got rdy=%b tag=%0d want rdy 0", alu_ready, tag);
        end
        cdb_lsb_done = 1'b1;
        cdb_lsb_tag  = 4'd10;
        cdb_lsb_data = 32'h100;
        tick();
        cdb_idle();
        checks++;
        if (rs_full !== 1'b1 || alu_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_wake got full=%b rdy=%b want 1 0", rs_full, alu_ready);
        end
        tick();
        checks++;
        if (alu_ready !== 1'b1 || tag !== 4'd14 || a !== 32'h100 || b !== 32'd2 || rs_full !== 1'b0) begin
            errors++;
            $display("FAIL full_issue got rdy=%b tag=%0d a=%h b=%0d full=%b want 1 14 100 2 0",
                     alu_ready, tag, a, b, rs_full);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        cdb_alu_done = 1'b1;
        cdb_alu_tag  = 4'd9;
        cdb_alu_data = 32'h200;
        cdb_lsb_done = 1'b1;
        cdb_lsb_tag  = 4'd11;
        cdb_lsb_data = 32'h300;
        tick();
        cdb_idle();
        tick();
        checks++;
        if (alu_ready !== 1'b1 || tag !== 4'd13 || a !== 32'h200 || b !== 32'd1) begin
            errors++;
            $display("FAIL b2b_first got rdy=%b tag=%0d a=%h b=%0d want 1 13 200 1",
                     alu_ready, tag, a, b);
        end
        tick();
        checks++;
        if (alu_ready !== 1'b1 || tag !== 4'd15 || a !== 32'h300 || b !== 32'd3) begin
            errors++;
            $display("FAIL b2b_second got rdy=%b tag=%0d a=%h b=%0d want 1 15 300 3",
                     alu_ready, tag, a, b);
        end
        tick();
        checks++;
        if (alu_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain got rdy=%b want 0", alu_ready);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            set_disp(1'b1, 5'd3, 4'(1 + i), 32'd0, 32'd0, 4'd5, 4'd0, 1'b1, 1'b0);
            tick();
        end
        set_disp(1'b0, 5'd0, 4'd0, 32'd0, 32'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        checks++;
        if (rs_full !== 1'b1) begin
            errors++;
            $display("FAIL flush_prefill got full=%b want 1", rs_full);
        end
        cdb_alu_done = 1'b1;
        cdb_alu_tag  = 4'd8;
        cdb_alu_data = 32'h800;
        tick();
        cdb_idle();
        flush = 1'b1;
        set_disp(1'b1, 5'd4, 4'd6, 32'd1, 32'd1, 4'd0, 4'd0, 1'b0, 1'b0);
        tick();
        flush = 1'b0;
        set_disp(1'b0, 5'd0, 4'd0, 32'd0, 32'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        checks++;
        if (alu_ready !== 1'b0 || rs_full !== 1'b0) begin
            errors++;
            $display("FAIL flush_edge got rdy=%b full=%b want 0 0", alu_ready, rs_full);
        end
        tick();
        checks++;
        if (alu_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_drop got rdy=%b tag=%0d want 0", alu_ready, tag);
        end
        cdb_lsb_done = 1'b1;
        cdb_lsb_tag  = 4'd5;
        cdb_lsb_data = 32'h5;
        tick();
        cdb_idle();
        tick();
        checks++;
        if (alu_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_stale got rdy=%b tag=%0d want 0", alu_ready, tag);
        end
    endtask

    task automatic test_async_reset();
        set_disp(1'b1, 5'd16, 4'd9, 32'h33, 32'h44, 4'd0, 4'd0, 1'b0, 1'b0);
        tick();
        set_disp(1'b1, 5'd0, 4'd10, 32'h1, 32'h2, 4'd0, 4'd0, 1'b0, 1'b0);
        tick();
        set_disp(1'b0, 5'd0, 4'd0, 32'd0, 32'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        checks++;
        if (alu_ready !== 1'b1 || a !== 32'h33 || alu_op !== 5'd16 || tag !== 4'd9) begin
            errors++;
            $display("FAIL pre_reset got rdy=%b a=%h op=%0d tag=%0d want 1 33 16 9",
                     alu_ready, a, alu_op, tag);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (alu_ready !== 1'b0 || a !== 32'd0 || b !== 32'd0 || alu_op !== 5'd0 || tag !== 4'd0) begin
            errors++;
            $display("FAIL async_reset got rdy=%b a=%h b=%h op=%0d tag=%0d want zeros",
                     alu_ready, a, b, alu_op, tag);
        end
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if (alu_ready !== 1'b0 || rs_full !== 1'b0) begin
            errors++;
            $display("FAIL reset_drop got rdy=%b full=%b want 0 0", alu_ready, rs_full);
        end
    endtask

    initial begin
        test_reset();
        test_dispatch();
        test_wakeup();
        test_forward();
        test_full();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_rs.md
# alu_rs

Reservation station for the integer ALU: holds up to `DEPTH` dispatched ALU operations and tracks operand dependencies by tag. It captures operand values broadcast on the two common data buses (ALU and load/store) and issues at most one ready operation per cycle to the ALU. It sits between the dispatch/rename stage and the ALU; its issue outputs connect directly to the ALU's `alu_ready/a/b/alu_op/tag` inputs.

## Interface
- `DEPTH`, 4: number of entries, a power of two, 2..16.
- `TAG_W`, 4: tag width; must match the ALU tag width.
- `OP_W`, 5: ALU opcode width.
- `clk` in 1: single clock, all state on posedge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `flush` in 1: misprediction flush; invalidates all entries.
- `disp_valid` in 1: dispatch request.
- `disp_op` in OP_W: ALU opcode.
- `disp_tag` in TAG_W: destination tag.
- `disp_vj`, `disp_vk` in 32: operand values, meaningful when not pending.
- `disp_qj`, `disp_qk` in TAG_W: producer tags.
- `disp_pj`, `disp_pk` in 1: operand pending; waits for producer tag.
- `rs_full` out 1: no free entry; registered.
- `cdb_alu_done`, `cdb_alu_tag`, `cdb_alu_data` in 1/TAG_W/32: ALU broadcast.
- `cdb_lsb_done`, `cdb_lsb_tag`, `cdb_lsb_data` in 1/TAG_W/32: load/store broadcast.
- `alu_ready` out 1: issue valid to ALU; registered.
- `a`, `b` out 32: issued operands.
- `alu_op` out OP_W; `tag` out TAG_W: issued opcode and tag.

## Operation
- Entry state: busy, op, tag, vj, vk, qj, qk, pj, pk. Ready means busy && !pj && !pk, evaluated on registered state.
- Dispatch is accepted when `disp_valid && !rs_full && !flush`. The entry is written into the lowest-index free slot.
- Dispatch forwarding: if a pending operand's tag matches a CDB broadcast in the same cycle, store the data with pending cleared. ALU bus is checked before LSB bus; both matching the same tag is illegal.
- Wakeup: each cycle, every busy pending operand whose q matches a valid CDB tag captures the data and clears pending.
- Issue: the lowest-index ready entry is selected. Its busy bit clears at the edge, and `alu_ready/a/b/alu_op/tag` load it at the same edge. With no ready entry, `alu_ready` is 0 and the other outputs hold their values.
- `rs_full` is registered as next_count == DEPTH, where next_count = count + accept − issue. A full station that issues this cycle still rejects dispatch this cycle.
- `flush` clears all busy bits and `alu_ready`, and sets `rs_full` to 0 at the next edge. It has priority over dispatch, issue and wakeup.
- Reset values: all busy bits 0; `alu_ready` 0; `a`, `b`, `alu_op`, `tag` 0; `rs_full` 0.

## Timing
- Minimum latency is 1 cycle: dispatch of ready operands at edge N gives `alu_ready` after edge N+1.
- Wakeup from a broadcast in cycle N makes the entry eligible in cycle N+1; `alu_ready` is asserted after edge N+2. Same-cycle forwarding yields the same timing.
- Back-to-back throughput is one issue per cycle; the ALU accepts every cycle with no backpressure.
- An asynchronous reset assertion mid-operation drops all entries immediately.

## Structure
- Shared package `rs_pkg`: ALU opcode constants 0..16 (ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU, EQ, NE, GE, GEU, SLTI, SLTIU, MUL), `TAG_W`, `OP_W`, and the entry struct type.
- One sub-module, `rs_pick`: a parameterised lowest-index priority encoder producing found + index. It is used twice, once for the free slot and once for the ready entry.

## Test plan
- Dispatch ADD with vj=5, vk=7, no pending -> `alu_ready`=1 with a=5, b=7, alu_op=0, tag=tag one cycle after the dispatch edge.
- Dispatch SUB with qj=3 pending and vk=1; next cycle `cdb_lsb_done` with tag 3, data 10 -> issue a=10, b=1 two edges after the broadcast.
- Dispatch with qk=6 while `cdb_alu_tag`=6 and data 0x55 in the same cycle -> entry issues immediately with b=0x55; no hang.
- Fill 4 entries all pending -> `rs_full`=1 and a 5th dispatch is ignored. Wake entry 2 -> it issues, then `rs_full` falls after the next edge.
- Entries 1 and 3 become ready together -> entry 1 issues first, entry 3 on the next cycle.
- `flush` asserted with 3 busy entries and `disp_valid`=1 -> `alu_ready`=0, no issue, `rs_full`=0, and the dispatched op is dropped. Asynchronous `rst_n` low mid-run -> outputs 0 immediately.
